fsm_cmd_cond: RTL and testbench

- Input-conditioning stage that sits directly upstream of the control FSM.
- Takes four raw, asynchronous, bouncy operator inputs: go button, jmp button and a 2-bit skip switch.
- Drives the FSM inputs `go`, `jmp`, `sk0` and `sk1`.
- Synchronises and debounces every input. Converts button presses into single-cycle pulses. Presents the skip code atomically, so the FSM never sees a mixed code.

---
 rtl/fsm_cmd_cond.sv | 138 +++++++++++++
 tb/tb_fsm_cmd_cond.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_cmd_cond.sv
// rtl/fsm_cmd_cond.sv - operator input conditioning for the control FSM
// Synchronises, debounces and edge-detects go/jmp, and presents the skip code atomically.

module fsm_cmd_cond_chan #(
  parameter int DEB_CNT = 8,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic lvl,
  output logic stable
);

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CNT - 1);

  logic             s1, s2;
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Counter only advances while qualifying an edge and stops at LAST, so it cannot wrap.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      LOW: begin
        if (s2) begin
          state_nx = RISE;
          cnt_nx   = '0;
        end
      end
      RISE: begin
        if (!s2)              state_nx = LOW;
        else if (cnt == LAST) state_nx = HIGH;
        else                  cnt_nx   = cnt + CNT_W'(1);
      end
      HIGH: begin
        if (!s2) begin
          state_nx = FALL;
          cnt_nx   = '0;
        end
      end
      FALL: begin
        if (s2)               state_nx = HIGH;
        else if (cnt == LAST) state_nx = LOW;
        else                  cnt_nx   = cnt + CNT_W'(1);
      end
      default: begin
        state_nx = LOW;
        cnt_nx   = '0;
      end
    endcase
  end

  assign lvl    = (state == HIGH) || (state == FALL);
  assign stable = (state == LOW)  || (state == HIGH);

endmodule

module fsm_cmd_cond #(
  parameter int DEB_CNT = 8,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go_raw,
  input  logic       jmp_raw,
  input  logic [1:0] sk_raw,
  output logic       go,
  output logic       jmp,
  output logic       sk0,
  output logic       sk1,
  output logic       sk_upd
);

  // Channel order: 0 = go, 1 = jmp, 2 = sk[0], 3 = sk[1].
  logic [3:0] raw_v;
  logic [3:0] lvl;
  logic [3:0] stable;
  logic       go_lvl_d, jmp_lvl_d;

  assign raw_v = {sk_raw, jmp_raw, go_raw};

  for (genvar i = 0; i < 4; i++) begin : g_chan
    fsm_cmd_cond_chan #(
      .DEB_CNT(DEB_CNT),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_v[i]),
      .lvl   (lvl[i]),
      .stable(stable[i])
    );
  end

  // The filtered level only rises on RISE->HIGH, so its rising edge is exactly one accepted press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_lvl_d  <= 1'b0;
      jmp_lvl_d <= 1'b0;
      go        <= 1'b0;
      jmp       <= 1'b0;
      sk0       <= 1'b0;
      sk1       <= 1'b0;
      sk_upd    <= 1'b0;
    end else begin
      go_lvl_d  <= lvl[0];
      jmp_lvl_d <= lvl[1];
      go        <= lvl[0] & ~go_lvl_d;
      jmp       <= lvl[1] & ~jmp_lvl_d;
      if (stable[2] && stable[3]) begin
        sk0    <= lvl[2];
        sk1    <= lvl[3];
        sk_upd <= (lvl[3:2] != {sk1, sk0});
      end else begin
        sk_upd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_cmd_cond.sv
// tb/tb_fsm_cmd_cond.sv - self-checking bench for fsm_cmd_cond
// Reference model: a channel accepts a new level after DEB+1 equal samples taken two edges late.

module tb_fsm_cmd_cond;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go_raw = 1'b0;
  logic       jmp_raw = 1'b0;
  logic [1:0] sk_raw = 2'b00;
  logic       go, jmp, sk0, sk1, sk_upd;

  always #5 clk = ~clk;

  fsm_cmd_cond #(
    .DEB_CNT(DEB),
    .CNT_W  (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go_raw (go_raw),
    .jmp_raw(jmp_raw),
    .sk_raw (sk_raw),
    .go     (go),
    .jmp    (jmp),
    .sk0    (sk0),
    .sk1    (sk1),
    .sk_upd (sk_upd)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [3:0]      s1;
    logic [3:0]      s2;
    logic [3:0]      lvl;
    logic [3:0]      runv;
    logic [3:0][7:0] runn;
    logic            go_p;
    logic            jmp_p;
    logic            go;
    logic            jmp;
    logic            sk0;
    logic            sk1;
    logic            upd;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_step(mstate_t c, logic [3:0] raw);
    mstate_t    n;
    logic [3:0] samp;
    logic [3:0] rose;
    n    = c;
    rose = '0;
    // Skip register sees the channels as they were during the cycle ending at this edge.
    if (c.lvl[2] == c.runv[2] && c.lvl[3] == c.runv[3]) begin
      n.upd = (c.lvl[3:2] != {c.sk1, c.sk0});
      n.sk0 = c.lvl[2];
      n.sk1 = c.lvl[3];
    end else begin
      n.upd = 1'b0;
    end
    n.go  = c.go_p;
    n.jmp = c.jmp_p;
    samp  = c.s2;
    n.s2  = c.s1;
    n.s1  = raw;
    for (int ch = 0; ch < 4; ch++) begin
      if (samp[ch] == c.runv[ch]) begin
        n.runn[ch] = (c.runn[ch] < 8'd200) ? c.runn[ch] + 8'd1 : c.runn[ch];
      end else begin
        n.runv[ch] = samp[ch];
        n.runn[ch] = 8'd1;
      end
      if (n.runv[ch] != c.lvl[ch] && int'(n.runn[ch]) >= DEB + 1) n.lvl[ch] = n.runv[ch];
      rose[ch] = !c.lvl[ch] && n.lvl[ch];
    end
    n.go_p  = rose[0];
    n.jmp_p = rose[1];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, {sk_raw, jmp_raw, go_raw});
  end

  int checks = 0;
  int errors = 0;
  int go_cnt, jmp_cnt, upd_cnt, go_cyc, jmp_cyc, upd_cyc, upd_val, saw01;
  int k, r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_mon();
    go_cnt  = 0; jmp_cnt = 0; upd_cnt = 0;
    go_cyc  = -1; jmp_cyc = -1; upd_cyc = -1; upd_val = -1; saw01 = 0;
  endtask

  task automatic step(input int n);
    logic [4:0] act, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      act = {go, jmp, sk1, sk0, sk_upd};
      exp = {m.go, m.jmp, m.sk1, m.sk0, m.upd};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp cycle %0d: {go,jmp,sk1,sk0,sk_upd} got %b expected %b", cyc, act, exp);
      end
      if (go)     begin go_cnt++;  go_cyc  = cyc; end
      if (jmp)    begin jmp_cnt++; jmp_cyc = cyc; end
      if (sk_upd) begin upd_cnt++; upd_cyc = cyc; upd_val = int'({sk1, sk0}); end
      if ({sk1, sk0} == 2'b01) saw01 = 1;
    end
  endtask

  initial begin
    clear_mon();
    step(3);
    chk("reset_outputs", int'({go, jmp, sk0, sk1, sk_upd}), 0);
    rst_n = 1'b1;

    // 1: idle
    step(10);
    chk("idle_pulses", go_cnt + jmp_cnt + upd_cnt, 0);

    // 2: go held high
    clear_mon();
    go_raw = 1'b1;
    k = cyc + 1;
    step(20);
    chk("go_count", go_cnt, 1);
    chk("go_latency", go_cyc - k, 7);
    chk("go_no_jmp", jmp_cnt, 0);
    go_raw = 1'b0;
    step(12);

    // glitch boundary: DEB cycles rejected, DEB+1 accepted
    clear_mon();
    go_raw = 1'b1; step(DEB); go_raw = 1'b0; step(12);
    chk("glitch_short", go_cnt, 0);
    go_raw = 1'b1; step(DEB + 1); go_raw = 1'b0; step(14);
    chk("glitch_long", go_cnt, 1);

    // 3: jmp bounce then hold
    clear_mon();
    jmp_raw = 1'b1; step(1); jmp_raw = 1'b0; step(1);
    jmp_raw = 1'b1; step(1); jmp_raw = 1'b0; step(1);
    jmp_raw = 1'b1;
    k = cyc + 1;
    step(20);
    chk("jmp_count", jmp_cnt, 1);
    chk("jmp_latency", jmp_cyc - k, 7);
    jmp_raw = 1'b0;
    step(12);

    // 4: skip code 00->11 with bit1 lagging
    clear_mon();
    sk_raw = 2'b01;
    k = cyc + 1;
    step(2);
    sk_raw = 2'b11;
    step(20);
    chk("sk_upd_count", upd_cnt, 1);
    chk("sk_never_01", saw01, 0);
    chk("sk_upd_value", upd_val, 3);
    chk("sk_upd_cycle", upd_cyc - k, 9);
    sk_raw = 2'b00;
    step(15);
    chk("sk_back_count", upd_cnt, 2);
    chk("sk_back_value", upd_val, 0);

    // 5: simultaneous go and jmp
    clear_mon();
    go_raw = 1'b1; jmp_raw = 1'b1;
    k = cyc + 1;
    step(20);
    chk("both_go", go_cnt, 1);
    chk("both_jmp", jmp_cnt, 1);
    chk("both_same_cycle", go_cyc - jmp_cyc, 0);
    chk("both_latency", go_cyc - k, 7);
    go_raw = 1'b0; jmp_raw = 1'b0;
    step(12);

    // 6: reset mid-RISE with go held
    clear_mon();
    go_raw = 1'b1;
    step(4);
    rst_n = 1'b0;
    step(2);
    chk("rst_no_pulse", go_cnt, 0);
    rst_n = 1'b1;
    r = cyc + 1;
    step(15);
    chk("rst_go_count", go_cnt, 1);
    chk("rst_go_latency", go_cyc - r, 7);
    go_raw = 1'b0;
    step(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
